// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code-lock controller.
// Imported by the lock FSM and its digit buffer.
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED,
    UNLOCKED,
    NEW_CODE,
    CONFIRM,
    LOCKOUT
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t KEY_CLEAR_CODE = 4'hA;
  localparam bcd_t KEY_ENTER_CODE = 4'hB;

  function automatic logic is_bcd(bcd_t k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_code_buffer.sv
// Digit entry window: shift register plus saturating count.
// Once full, new digits push the oldest one out.
module code_buffer
  import lock_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         shift_i,
  input  logic                         clr_i,
  input  bcd_t                         digit_i,
  output logic [4*DIGITS-1:0]          buf_o,
  output logic [$clog2(DIGITS+1)-1:0]  cnt_o,
  output logic                         full_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == FULL_CNT);
  assign buf_o  = buf_q;
  assign cnt_o  = cnt_q;

  // Clear wins over shift; count stops at DIGITS.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      buf_d = BW'({buf_q, digit_i});
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end
  end

  // Window and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad code lock: user/master code check, two-step code
// change with confirmation, and failed-attempt lockout.
module keypad_lock_ctrl
#(
  parameter int                 DIGITS         = 6,
  parameter logic [4*DIGITS-1:0] MASTER_CODE   = 24'h555116,
  parameter logic [4*DIGITS-1:0] DEFAULT_UC    = 24'h666666,
  parameter int                 MAX_TRIES      = 3,
  parameter int                 LOCKOUT_CYCLES = 36000000,
  parameter logic [3:0]         KEY_CLEAR      = lock_pkg::KEY_CLEAR_CODE,
  parameter logic [3:0]         KEY_ENTER      = lock_pkg::KEY_ENTER_CODE
) (
  input  logic                          hwclk,
  input  logic                          reset,
  input  logic [3:0]                    key,
  input  logic                          key_valid,
  output logic                          unlocked,
  output logic                          programming,
  output logic                          locked_out,
  output logic                          ok_pulse,
  output logic                          err_pulse,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  import lock_pkg::*;

  localparam int BW  = 4 * DIGITS;
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TMW = (LOCKOUT_CYCLES > 1) ?
                       $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TRW-1:0] TRIES_INIT = TRW'(MAX_TRIES);
  localparam logic [TMW-1:0] TIMER_INIT = TMW'(LOCKOUT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [TRW-1:0] tries_q, tries_d;
  logic [TMW-1:0] timer_q, timer_d;
  logic [BW-1:0]  uc_q, uc_d;
  logic [BW-1:0]  pend_q, pend_d;
  logic           ok_q, ok_d;
  logic           err_q, err_d;
  logic           unl_q, prog_q, lo_q;

  logic           is_dig, is_clr, is_ent;
  logic           buf_shift, buf_clr, buf_full;
  logic [BW-1:0]  buf_val;

  assign is_dig = key_valid && is_bcd(key);
  assign is_clr = key_valid && (key == KEY_CLEAR);
  assign is_ent = key_valid && (key == KEY_ENTER);

  code_buffer #(
    .DIGITS (DIGITS)
  ) u_buf (
    .clk_i   (hwclk),
    .rst_i   (reset),
    .shift_i (buf_shift),
    .clr_i   (buf_clr),
    .digit_i (key),
    .buf_o   (buf_val),
    .cnt_o   (digit_count),
    .full_o  (buf_full)
  );

  // Next-state, tries, timer, code registers and pulses.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    uc_d      = uc_q;
    pend_d    = pend_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    buf_shift = 1'b0;
    buf_clr   = 1'b0;
    unique case (state_q)
      LOCKED: begin
        buf_shift = is_dig;
        buf_clr   = is_clr | is_ent;
        if (is_ent) begin
          if (buf_full && buf_val == uc_q) begin
            state_d = UNLOCKED;
            ok_d    = 1'b1;
            tries_d = TRIES_INIT;
          end else if (buf_full && buf_val == MASTER_CODE) begin
            state_d = NEW_CODE;
            tries_d = TRIES_INIT;
          end else begin
            err_d = 1'b1;
            if (tries_q <= TRW'(1)) begin
              tries_d = '0;
              timer_d = TIMER_INIT;
              state_d = LOCKOUT;
            end else begin
              tries_d = tries_q - TRW'(1);
            end
          end
        end
      end
      UNLOCKED: begin
        buf_clr = is_ent;
        if (is_ent) state_d = LOCKED;
      end
      NEW_CODE: begin
        buf_shift = is_dig;
        buf_clr   = is_clr | is_ent;
        if (is_ent) begin
          if (buf_full) begin
            pend_d  = buf_val;
            state_d = CONFIRM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CONFIRM: begin
        buf_shift = is_dig;
        buf_clr   = is_clr | is_ent;
        if (is_ent) begin
          state_d = LOCKED;
          if (buf_full && buf_val == pend_q) begin
            uc_d = pend_q;
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = LOCKED;
          tries_d = TRIES_INIT;
        end else begin
          timer_d = timer_q - TMW'(1);
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  // State, counters, codes and registered outputs.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= LOCKED;
      tries_q <= TRIES_INIT;
      timer_q <= '0;
      uc_q    <= DEFAULT_UC;
      pend_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      unl_q   <= 1'b0;
      prog_q  <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      uc_q    <= uc_d;
      pend_q  <= pend_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      unl_q   <= (state_d == UNLOCKED);
      prog_q  <= (state_d == NEW_CODE) ||
                 (state_d == CONFIRM);
      lo_q    <= (state_d == LOCKOUT);
    end
  end

  assign unlocked    = unl_q;
  assign programming = prog_q;
  assign locked_out  = lo_q;
  assign ok_pulse    = ok_q;
  assign err_pulse   = err_q;
  assign tries_left  = tries_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Self-checking bench for keypad_lock_ctrl (DIGITS=6, 3 tries,
// 100-cycle lockout). Expected ENTER outcomes go through a queue.
module tb_keypad_lock_ctrl;

  localparam logic [3:0] CLR = 4'hA;
  localparam logic [3:0] ENT = 4'hB;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = 4'h0;
  logic       key_valid = 1'b0;
  logic       unlocked, programming, locked_out;
  logic       ok_pulse, err_pulse;
  logic [2:0] digit_count;
  logic [1:0] tries_left;

  int tests = 0;
  int fails = 0;
  logic [6:0] sb[$];

  always #5 hwclk = ~hwclk;

  keypad_lock_ctrl #(
    .DIGITS         (6),
    .MASTER_CODE    (24'h555116),
    .DEFAULT_UC     (24'h666666),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (100)
  ) dut (
    .hwclk       (hwclk),
    .reset       (reset),
    .key         (key),
    .key_valid   (key_valid),
    .unlocked    (unlocked),
    .programming (programming),
    .locked_out  (locked_out),
    .ok_pulse    (ok_pulse),
    .err_pulse   (err_pulse),
    .digit_count (digit_count),
    .tries_left  (tries_left)
  );

  // {ok, err, unlocked, programming, locked_out, tries}
  function automatic logic [6:0] mk(logic ok, logic er, logic un,
                                    logic pr, logic lo,
                                    logic [1:0] tr);
    return {ok, er, un, pr, lo, tr};
  endfunction

  function automatic logic [6:0] obs();
    return {ok_pulse, err_pulse, unlocked, programming,
            locked_out, tries_left};
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge hwclk);
    key = k;
    key_valid = 1'b1;
    @(posedge hwclk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic type_code(input int n, input logic [31:0] c);
    for (int i = n - 1; i >= 0; i--) press(c[4*i +: 4]);
  endtask

  task automatic ent(input logic [6:0] e);
    sb.push_back(e);
    press(ENT);
  endtask

  task automatic do_reset();
    @(negedge hwclk);
    reset = 1'b1;
    repeat (2) @(posedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
  endtask

  task automatic run_seq(input string nm, input int n,
                         input logic [31:0] codes[],
                         input int lens[],
                         input logic [6:0] exps[]);
    logic [6:0] e;
    logic [6:0] o;
    for (int i = 0; i < n; i++) begin
      type_code(lens[i], codes[i]);
      ent(exps[i]);
      e = sb.pop_front();
      o = obs();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s[%0d]: got %b want %b", nm, i, o, e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (obs() !== mk(0, 0, 0, 0, 0, 3)) begin
      fails++;
      $display("FAIL reset_out: got %b want %b",
               obs(), mk(0, 0, 0, 0, 0, 3));
    end
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d want 0", digit_count);
    end
  endtask

  task automatic test_unlock();
    do_reset();
    type_code(6, 32'h666666);
    tests++;
    if (digit_count !== 3'd6) begin
      fails++;
      $display("FAIL unl_cnt: got %0d want 6", digit_count);
    end
    run_seq("unlock", 1, '{32'h0}, '{0}, '{mk(1, 0, 1, 0, 0, 3)});
    @(posedge hwclk);
    #1;
    tests++;
    if (ok_pulse !== 1'b0 || unlocked !== 1'b1) begin
      fails++;
      $display("FAIL ok_width: got ok=%b unl=%b want ok=0 unl=1",
               ok_pulse, unlocked);
    end
    run_seq("relock", 1, '{32'h0}, '{0}, '{mk(0, 0, 0, 0, 0, 3)});
  endtask

  task automatic test_lockout();
    time t0;
    int  cyc;
    do_reset();
    run_seq("fail", 4,
            '{32'h123, 32'h123456, 32'h999999, 32'h666666},
            '{3, 6, 6, 6},
            '{mk(0, 1, 0, 0, 0, 2), mk(0, 1, 0, 0, 0, 1),
              mk(0, 1, 0, 0, 1, 0), mk(0, 0, 0, 0, 1, 0)});
    t0 = $time - 10 * 7;
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL lo_cnt: got %0d want 0", digit_count);
    end
    cyc = 0;
    while (locked_out === 1'b1 && cyc < 300) begin
      @(posedge hwclk);
      #1;
      cyc++;
    end
    tests++;
    if (locked_out !== 1'b0) begin
      fails++;
      $display("FAIL lo_timeout: got locked_out=%b want 0",
               locked_out);
    end
    tests++;
    if (($time - t0) !== 64'd1000) begin
      fails++;
      $display("FAIL lo_len: got %0d want 1000", $time - t0);
    end
    tests++;
    if (tries_left !== 2'd3) begin
      fails++;
      $display("FAIL lo_tries: got %0d want 3", tries_left);
    end
    run_seq("after_lo", 1, '{32'h666666}, '{6},
            '{mk(1, 0, 1, 0, 0, 3)});
  endtask

  task automatic test_change();
    do_reset();
    run_seq("change", 7,
            '{32'h555116, 32'h12, 32'h123456, 32'h123456,
              32'h666666, 32'h123456, 32'h0},
            '{6, 2, 6, 6, 6, 6, 0},
            '{mk(0, 0, 0, 1, 0, 3), mk(0, 1, 0, 1, 0, 3),
              mk(0, 0, 0, 1, 0, 3), mk(1, 0, 0, 0, 0, 3),
              mk(0, 1, 0, 0, 0, 2), mk(1, 0, 1, 0, 0, 3),
              mk(0, 0, 0, 0, 0, 3)});
  endtask

  task automatic test_mismatch();
    do_reset();
    run_seq("mismatch", 4,
            '{32'h555116, 32'h123456, 32'h123457, 32'h666666},
            '{6, 6, 6, 6},
            '{mk(0, 0, 0, 1, 0, 3), mk(0, 0, 0, 1, 0, 3),
              mk(0, 1, 0, 0, 0, 3), mk(1, 0, 1, 0, 0, 3)});
  endtask

  task automatic test_entry_edit();
    do_reset();
    type_code(8, 32'h12666666);
    tests++;
    if (digit_count !== 3'd6) begin
      fails++;
      $display("FAIL wrap_cnt: got %0d want 6", digit_count);
    end
    run_seq("wrap", 2, '{32'h0, 32'h0}, '{0, 0},
            '{mk(1, 0, 1, 0, 0, 3), mk(0, 0, 0, 0, 0, 3)});
    type_code(3, 32'h666);
    press(CLR);
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL clr_cnt: got %0d want 0", digit_count);
    end
    run_seq("clear", 2, '{32'h666666, 32'h0}, '{6, 0},
            '{mk(1, 0, 1, 0, 0, 3), mk(0, 0, 0, 0, 0, 3)});
    type_code(3, 32'h666);
    press(4'hF);
    type_code(3, 32'h666);
    tests++;
    if (digit_count !== 3'd6) begin
      fails++;
      $display("FAIL ign_cnt: got %0d want 6", digit_count);
    end
    run_seq("ignore", 1, '{32'h0}, '{0},
            '{mk(1, 0, 1, 0, 0, 3)});
  endtask

  task automatic test_async_reset();
    do_reset();
    run_seq("pre_rst", 2, '{32'h555116, 32'h123456}, '{6, 6},
            '{mk(0, 0, 0, 1, 0, 3), mk(0, 0, 0, 1, 0, 3)});
    type_code(2, 32'h12);
    @(negedge hwclk);
    reset = 1'b1;
    #1;
    tests++;
    if (obs() !== mk(0, 0, 0, 0, 0, 3) || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL async_rst: got %b cnt %0d want %b cnt 0",
               obs(), digit_count, mk(0, 0, 0, 0, 0, 3));
    end
    @(negedge hwclk);
    reset = 1'b0;
    run_seq("post_rst", 2, '{32'h123456, 32'h666666}, '{6, 6},
            '{mk(0, 1, 0, 0, 0, 2), mk(1, 0, 1, 0, 0, 3)});
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_change();
    test_mismatch();
    test_entry_edit();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Parametrised keypad code-lock controller; successor to the fixed 6-digit single-code lock controller.
- Consumes debounced key events from the keypad scanner. Holds a programmable user code and a fixed master code.
- Adds N-digit codes, CLEAR/ENTER keys, two-step code change with confirmation, and a failed-attempt lockout.
- Drives lock status and single-cycle ok/err pulses that feed the LED pattern generator.

Parameters:
- DIGITS, 6, code length in BCD digits (1..8).
- MASTER_CODE, 24'h555116, master code, 4*DIGITS bits BCD, MS digit first.
- DEFAULT_UC, 24'h666666, user code loaded at reset.
- MAX_TRIES, 3, consecutive failed ENTERs that trigger lockout (>=1).
- LOCKOUT_CYCLES, 36000000, lockout duration in hwclk cycles (3 s at 12 MHz).
- KEY_CLEAR, 4'hA, key code for '*'.
- KEY_ENTER, 4'hB, key code for '#'.

Ports:
- hwclk  in  1  12 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- key  in  4  key code: 0-9 digits, KEY_CLEAR, KEY_ENTER; other values ignored.
- key_valid  in  1  one-cycle strobe; key is sampled when high.
- unlocked  out  1  high while in UNLOCKED.
- programming  out  1  high in NEW_CODE or CONFIRM.
- locked_out  out  1  high in LOCKOUT.
- ok_pulse  out  1  one-cycle pulse on successful unlock or code change.
- err_pulse  out  1  one-cycle pulse on any rejected ENTER.
- digit_count  out  $clog2(DIGITS+1)  digits currently buffered.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout.

Behaviour:
- Reset (async):
  - state=LOCKED; buffer=0; digit_count=0; tries_left=MAX_TRIES; UC=DEFAULT_UC; timer=0.
  - All pulse and status outputs 0.
  - Reset mid-operation discards any pending new code.
- Digit key (0-9), outside LOCKOUT and UNLOCKED:
  - buffer <= {buffer[4*DIGITS-5:0], key}.
  - digit_count saturates at DIGITS. Once full, the oldest digit is dropped (shift-window wrap).
- CLEAR: buffer=0, digit_count=0, state unchanged, no pulse.
- Keys other than digits, CLEAR and ENTER: ignored in every state.
- Every ENTER clears buffer and digit_count in the same cycle it is decided.
- All outputs are registered. Pulses assert the cycle after the ENTER strobe.
- LOCKED, on ENTER:
  - digit_count==DIGITS and buffer==UC -> UNLOCKED; ok_pulse; tries_left=MAX_TRIES.
  - Else if digit_count==DIGITS and buffer==MASTER_CODE -> NEW_CODE; no pulse; tries_left=MAX_TRIES. If UC==MASTER_CODE, the UC match wins.
  - Else -> err_pulse; tries_left-1. When it reaches 0 -> LOCKOUT with timer=LOCKOUT_CYCLES-1.
  - A short entry (digit_count<DIGITS) counts as a failure.
- UNLOCKED:
  - Digits and CLEAR ignored.
  - ENTER -> LOCKED (relock), no pulse.
- NEW_CODE:
  - ENTER with DIGITS digits -> latch pending=buffer -> CONFIRM.
  - Short ENTER -> err_pulse, stay in NEW_CODE.
- CONFIRM:
  - ENTER with DIGITS digits and buffer==pending -> UC=pending; ok_pulse -> LOCKED.
  - Mismatch or short ENTER -> err_pulse -> LOCKED, UC unchanged.
  - NEW_CODE and CONFIRM failures do not decrement tries_left.
- LOCKOUT:
  - All keys ignored; timer decrements every cycle.
  - At timer==0 -> LOCKED; tries_left=MAX_TRIES.
  - A key_valid arriving in the expiry cycle is dropped.
- A new code equal to MASTER_CODE is accepted; the UC check takes priority afterwards.

Decomposition:
- Shared package lock_pkg:
  - state enum: LOCKED, UNLOCKED, NEW_CODE, CONFIRM, LOCKOUT.
  - Key-code constants: KEY_CLEAR, KEY_ENTER.
  - BCD digit typedef (4 bits).
- One sub-module: code_buffer.
  - Shift register, saturating digit counter, clear.
  - Combinational full flag and buffer output.
- FSM, tries counter, lockout timer and UC/pending registers stay in keypad_lock_ctrl.

Test Plan (DIGITS=6, MAX_TRIES=3, LOCKOUT_CYCLES=100 in sim):
- Reset, keys 6,6,6,6,6,6,# -> ok_pulse one cycle, unlocked=1, tries_left=3; then # -> unlocked=0.
- Keys 1,2,3,# then 1,2,3,4,5,6,# then 9,9,9,9,9,9,# -> three err_pulses; tries_left 2,1,0; locked_out=1. Correct code typed during lockout is ignored. After 100 cycles locked_out=0, tries_left=3; 666666# then unlocks.
- Master 555116# -> programming=1; 123456#, 123456# -> ok_pulse, UC=123456; 666666# -> err; 123456# -> unlocked.
- Master, 123456#, 123457# -> err_pulse, back to LOCKED; 666666# still unlocks.
- Keys 1,2,6,6,6,6,6,6,# (8 digits, window wrap) -> unlocks. Keys 6,6,6,*,6,6,6,6,6,6,# -> unlocks (CLEAR works). Key 4'hF mid-entry ignored.
- Assert reset during CONFIRM -> state LOCKED, UC=666666, pending discarded, all outputs 0 immediately (async).
